regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (we/waddr/wdata) between the main pipeline
//  writeback (port A) and the long-latency producers, MDU/CP0 (port B, valid/ready).
//  A keeps priority. B is granted in idle slots, or by forcing a pipeline bubble after
//  STARVE_MAX lost cycles. A busy scoreboard marks registers awaiting a B result so
//  decode can stall on RAW hazards. Sits between the writeback stage and the regfile.
// PARAMETERS
//  ADDR_W      5   register address width (32 GPRs, $0 hardwired zero)
//  DATA_W      32  write data width
//  STARVE_MAX  4   consecutive cycles B may wait ungranted before a bubble is forced (>=2)
// PORTS
//  clk        in   1       system clock, rising-edge state updates
//  rst        in   1       synchronous reset, active-high
//  a_we       in   1       pipeline writeback enable
//  a_waddr    in   ADDR_W  pipeline writeback register
//  a_wdata    in   DATA_W  pipeline writeback data
//  b_valid    in   1       B has a result; held with stable addr/data until b_ready
//  b_ready    out  1       B result accepted this cycle
//  b_waddr    in   ADDR_W  B destination register
//  b_wdata    in   DATA_W  B result data
//  sb_set     in   1       decode issued a long-latency op; mark sb_addr busy
//  sb_addr    in   ADDR_W  destination register of the issued op
//  raddr1     in   ADDR_W  decode read address 1 (hazard query)
//  raddr2     in   ADDR_W  decode read address 2 (hazard query)
//  busy1      out  1       raddr1 awaits a B result
//  busy2      out  1       raddr2 awaits a B result
//  stall_req  out  1       request for a pipeline bubble (A must not write next slot)
//  err_drop   out  1       sticky: A write was lost during a forced B slot
//  rf_we      out  1       regfile write enable
//  rf_waddr   out  ADDR_W  regfile write address
//  rf_wdata   out  DATA_W  regfile write data
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, cnt=0, scoreboard=0, err_drop=0.
//    While rst=1: b_ready=0, rf_we=0, stall_req=0, busy1/2=0.
//  - Effective writes:
//    - a_eff = a_we & (a_waddr!=0).
//    - A B write to $0 is accepted (b_ready=1) whenever b_valid, with rf_we=0.
//  - States: IDLE, WAIT, FORCE. stall_req = (state==FORCE), a registered decode.
//  - Grant (combinational, same cycle):
//    - IDLE/WAIT: A wins if a_eff. Otherwise b_ready=b_valid.
//    - FORCE: b_ready=b_valid and B drives the port. If a_eff, the A write is dropped
//      and err_drop sets.
//    - rf_* carries the winner. rf_we=0 if there is no winner.
//  - Transitions:
//    - IDLE->WAIT when b_valid & ~b_ready, with cnt=1.
//    - WAIT: on b_ready -> IDLE, cnt=0. On ~b_valid -> IDLE, cnt=0.
//      Otherwise cnt++. When cnt==STARVE_MAX-1 and not granted -> FORCE.
//    - FORCE -> IDLE on the next cycle unconditionally; B is always granted there.
//    - Latency bound: a B result is written at most STARVE_MAX+1 cycles after b_valid rises.
//  - Scoreboard (32 bits, bit 0 constant 0):
//    - sb_set sets bit sb_addr. A B grant with b_waddr!=0 clears bit b_waddr.
//    - Set and clear of the same address in one cycle: set wins.
//    - sb_set with sb_addr already busy: stays busy (no counting).
//  - Hazard outputs (combinational):
//    - busy1 = sb[raddr1] & ~(b_ready & b_valid & b_waddr==raddr1 & raddr1!=0); busy2 likewise.
//    - The write in the same cycle makes the register readable, since the regfile
//      writes on the falling edge.
//  - Port A is never backpressured. The pipeline must honour stall_req in the same
//    cycle it is asserted.
// STRUCTURE
//  - Shared package: ADDR_W/DATA_W constants and the state encoding
//    (IDLE=2'd0, WAIT=2'd1, FORCE=2'd2).
//  - One sub-module: wb_scoreboard (busy vector, set/clear precedence, two query ports
//    with clear bypass). FSM and grant mux stay in the top level.
// TESTING
//  1. rst held 2 cycles with b_valid=1 and sb_set=1 -> rf_we=0, b_ready=0, busy1=0;
//     after release, sb=0.
//  2. a_we=1,a_waddr=8,a_wdata=0x11 and b_valid=1,b_waddr=9 in the same cycle ->
//     rf_waddr=8, data 0x11, b_ready=0. Next cycle with a_we=0 -> rf_waddr=9, b_ready=1.
//  3. a_we=1 (addr 5) every cycle, b_valid=1 (addr 6), STARVE_MAX=4 -> stall_req high
//     in cycle 4 after b_valid rose, B written that cycle. If a_we was kept high there,
//     err_drop=1.
//  4. sb_set addr 12, then raddr1=12 -> busy1=1. B grant to 12 -> busy1=0 that cycle
//     and cleared afterwards. sb_set(12) and B grant(12) together -> bit stays 1.
//  5. B write to $0 with b_wdata=0xFFFF -> b_ready=1, rf_we=0. sb_set addr 0 -> busy=0.
//  6. rst asserted while in FORCE -> state IDLE, stall_req=0 next cycle, scoreboard cleared.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and the arbiter state encoding for the regfile write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int RF_ADDR_W     = 5;
    localparam int RF_DATA_W     = 32;
    localparam int RF_STARVE_MAX = 4;

    // WAIT counts cycles that B has lost to A. FORCE is the one-cycle bubble
    // in which B owns the write port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Busy bit per register awaiting a port-B result, with two hazard query ports.
// Latency: set/clear take effect next cycle; a same-cycle clear bypasses to the queries.
// Backpressure: none; set and clear are accepted every cycle, and set wins on collision.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // Next busy vector: clear first so that a same-cycle set wins. $0 is never busy.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            sb_d[set_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // The regfile writes on the falling edge, so a register being written this
    // cycle is already readable by decode and must not report busy.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (!rst) begin
            busy1 = sb_q[raddr1] & ~(clr_en & (clr_addr == raddr1));
            busy2 = sb_q[raddr2] & ~(clr_en & (clr_addr == raddr2));
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback (A) and MDU/CP0 results (B).
// Latency: combinational grant; B is written at most STARVE_MAX+1 cycles after b_valid rises.
// Backpressure: A is never stalled; B waits on b_ready; a forced bubble is requested via stall_req.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int DATA_W     = RF_DATA_W,
    parameter int STARVE_MAX = RF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              stall_req,
    output logic              err_drop,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_drop_q, err_drop_d;

    logic              a_eff;
    logic              a_win;
    logic              b_grant;
    logic              sb_clr;

    assign a_eff = a_we & (a_waddr != '0);

    // Write-port grant: A has priority except in the forced slot, where B owns the port.
    always_comb begin
        a_win   = 1'b0;
        b_grant = 1'b0;
        if (!rst) begin
            if (state_q == ST_FORCE) begin
                b_grant = b_valid;
            end else begin
                a_win   = a_eff;
                b_grant = b_valid & ~a_eff;
            end
        end
        rf_we    = a_win | (b_grant & (b_waddr != '0));
        rf_waddr = a_win ? a_waddr : b_waddr;
        rf_wdata = a_win ? a_wdata : b_wdata;
    end

    assign b_ready   = b_grant;
    assign stall_req = ~rst & (state_q == ST_FORCE);
    assign err_drop  = err_drop_q;
    assign sb_clr    = b_grant & (b_waddr != '0);

    // Starvation tracking: count lost cycles and force a bubble on the limit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_drop_d = err_drop_q | ((state_q == ST_FORCE) & a_eff);
        case (state_q)
            ST_IDLE: begin
                if (b_valid && !b_grant) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (b_grant || !b_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STARVE_MAX - 1)) begin
                    state_d = ST_FORCE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FORCE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbiter state, starvation counter and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_drop_q <= err_drop_d;
        end
    end

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_addr (sb_addr),
        .clr_en   (sb_clr),
        .clr_addr (b_waddr),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

endmodule
